// File: rtl/ir_rx_pkg.sv
// =====================================================================
// Module : ir_rx_pkg
// Brief  : Shared types, car burst sizes and burst classifier for the IR receiver
// Rev    : 1.0 - initial release
// =====================================================================
`default_nettype none

package ir_rx_pkg;

   localparam int PCNT_W = 9;
   localparam int IDLE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_BURST = 2'd1,
      ST_IN_BURST   = 2'd2
   } ir_rx_state_t;

   typedef enum logic [1:0] {
      BC_S = 2'd0,
      BC_A = 2'd1,
      BC_D = 2'd2,
      BC_X = 2'd3
   } burst_class_t;

   typedef struct packed {
      int START_SIZE;
      int ASSERT_SIZE;
      int DEASSERT_SIZE;
   } car_settings_t;

   localparam car_settings_t CAR0 = '{START_SIZE: 191, ASSERT_SIZE: 47, DEASSERT_SIZE: 22};

   function automatic logic in_window(input logic [PCNT_W-1:0] cnt, input int centre, input int tol);
      return (int'(cnt) >= centre - tol) && (int'(cnt) <= centre + tol);
   endfunction

   function automatic burst_class_t classify(input logic [PCNT_W-1:0] cnt,
                                             input int start_size,
                                             input int assert_size,
                                             input int deassert_size,
                                             input int tol);
      if (in_window(cnt, start_size, tol))    return BC_S;
      if (in_window(cnt, assert_size, tol))   return BC_A;
      if (in_window(cnt, deassert_size, tol)) return BC_D;
      return BC_X;
   endfunction

   // Two inclusive +/-tol windows collide when their centres are within 2*tol.
   function automatic logic windows_overlap(input int a, input int b, input int tol);
      return ((a > b) ? (a - b) : (b - a)) <= 2 * tol;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ir_receiver_if.sv
// =====================================================================
// Module : ir_receiver_if
// Brief  : IR line input and decoded command outputs of the IR receiver
// Rev    : 1.0 - initial release
// =====================================================================
`default_nettype none

interface ir_receiver_if #(
   parameter int CMD_LEN = 4
);
   logic               IR_IN;
   logic [CMD_LEN-1:0] COMMAND;
   logic               VALID;
   logic               ERROR;
   logic               BUSY;

   modport master (
      output IR_IN,
      input  COMMAND,
      input  VALID,
      input  ERROR,
      input  BUSY
   );

   modport slave (
      input  IR_IN,
      output COMMAND,
      output VALID,
      output ERROR,
      output BUSY
   );
endinterface

`default_nettype wire

// File: rtl/ir_burst_counter.sv
// =====================================================================
// Module : ir_burst_counter
// Brief  : IR line synchroniser, rise detect, per-burst pulse count and gap timers
// Rev    : 1.0 - initial release
// =====================================================================
`default_nettype none

module ir_burst_counter
   import ir_rx_pkg::*;
#(
   parameter int GAP_CYCLES     = 10000,
   parameter int TIMEOUT_CYCLES = 4 * GAP_CYCLES
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ir_i,
   output logic              rise_o,
   output logic [PCNT_W-1:0] pcnt_o,
   output logic              burst_done_o,
   output logic              timeout_o
);

   localparam logic [IDLE_W-1:0] c_gap_end  = IDLE_W'(GAP_CYCLES - 1);
   localparam logic [IDLE_W-1:0] c_tmo_end  = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDLE_W-1:0] c_idle_max = IDLE_W'(TIMEOUT_CYCLES);
   localparam logic [PCNT_W-1:0] c_pcnt_max = '1;

   generate
      if ((TIMEOUT_CYCLES >= (2 ** IDLE_W)) || (GAP_CYCLES < 2) || (TIMEOUT_CYCLES <= GAP_CYCLES)) begin : g_param_check
         $error("ir_burst_counter: gap/timeout lengths do not fit the idle counter");
      end
   endgenerate

   logic              sync1_q;
   logic              sync2_q;
   logic              prev_q;
   logic              open_q;
   logic              open_d;
   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;
   logic [PCNT_W-1:0] burst_pcnt_q;
   logic [IDLE_W-1:0] idle_q;
   logic [IDLE_W-1:0] idle_d;
   logic              burst_done_q;
   logic              timeout_q;
   logic              w_rise;
   logic              w_end;
   logic              w_tmo;

   assign w_rise = sync2_q & ~prev_q;
   assign w_end  = open_q & ~w_rise & (idle_q == c_gap_end);
   assign w_tmo  = ~w_rise & (idle_q == c_tmo_end);

   // The idle timer keeps running after a burst closes so it also times the inter-burst wait.
   always_comb begin
      pcnt_d = pcnt_q;
      idle_d = idle_q;
      open_d = open_q;
      if (w_rise) begin
         if (pcnt_q != c_pcnt_max) begin
            pcnt_d = pcnt_q + 1'b1;
         end
         idle_d = '0;
         open_d = 1'b1;
      end else begin
         if (idle_q != c_idle_max) begin
            idle_d = idle_q + 1'b1;
         end
         if (w_end) begin
            pcnt_d = '0;
            open_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         pcnt_q       <= '0;
         idle_q       <= '0;
         open_q       <= 1'b0;
         burst_pcnt_q <= '0;
         burst_done_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         sync1_q      <= ir_i;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         pcnt_q       <= pcnt_d;
         idle_q       <= idle_d;
         open_q       <= open_d;
         burst_done_q <= w_end;
         timeout_q    <= w_tmo;
         if (w_end) begin
            burst_pcnt_q <= pcnt_q;
         end
      end
   end

   assign rise_o       = w_rise;
   assign pcnt_o       = burst_pcnt_q;
   assign burst_done_o = burst_done_q;
   assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: rtl/ir_receiver.sv
// =====================================================================
// Module : ir_receiver
// Brief  : Frame decoder turning classified IR bursts into a command word
// Rev    : 1.0 - initial release
// =====================================================================
`default_nettype none

module ir_receiver
   import ir_rx_pkg::*;
#(
   parameter int CMD_LEN       = 4,
   parameter int START_SIZE    = CAR0.START_SIZE,
   parameter int ASSERT_SIZE   = CAR0.ASSERT_SIZE,
   parameter int DEASSERT_SIZE = CAR0.DEASSERT_SIZE,
   parameter int TOL           = 3,
   parameter int GAP_CYCLES    = 10000
) (
   input  logic         CLK,
   input  logic         RESET,
   ir_receiver_if.slave bus
);

   localparam int BIDX_W = $clog2(CMD_LEN + 1);

   generate
      if (windows_overlap(START_SIZE, ASSERT_SIZE, TOL) ||
          windows_overlap(START_SIZE, DEASSERT_SIZE, TOL) ||
          windows_overlap(ASSERT_SIZE, DEASSERT_SIZE, TOL)) begin : g_window_check
         $error("ir_receiver: burst classification windows overlap");
      end
   endgenerate

   ir_rx_state_t        state_q;
   logic [BIDX_W-1:0]   bidx_q;
   logic [CMD_LEN-1:0]  shadow_q;
   logic [CMD_LEN-1:0]  command_q;
   logic                valid_q;
   logic                error_q;
   logic                busy_q;
   logic [CMD_LEN-1:0]  w_shadow_upd;
   logic [PCNT_W-1:0]   w_pcnt;
   logic                w_rise;
   logic                w_burst_done;
   logic                w_timeout;
   logic                w_last;
   burst_class_t        w_cls;

   ir_burst_counter #(
      .GAP_CYCLES     (GAP_CYCLES),
      .TIMEOUT_CYCLES (4 * GAP_CYCLES)
   ) u_counter (
      .CLK          (CLK),
      .RESET        (RESET),
      .ir_i         (bus.IR_IN),
      .rise_o       (w_rise),
      .pcnt_o       (w_pcnt),
      .burst_done_o (w_burst_done),
      .timeout_o    (w_timeout)
   );

   assign w_cls  = classify(w_pcnt, START_SIZE, ASSERT_SIZE, DEASSERT_SIZE, TOL);
   assign w_last = (bidx_q == BIDX_W'(CMD_LEN));

   // Command burst bidx lands in shadow bit bidx-1.
   always_comb begin
      w_shadow_upd = shadow_q;
      for (int i = 0; i < CMD_LEN; i++) begin
         if (int'(bidx_q) == i + 1) begin
            w_shadow_upd[i] = (w_cls == BC_A);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         bidx_q    <= '0;
         shadow_q  <= '0;
         command_q <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (w_rise) begin
                  state_q <= ST_IN_BURST;
                  bidx_q  <= '0;
               end
            end
            ST_WAIT_BURST: begin
               if (w_rise) begin
                  state_q <= ST_IN_BURST;
               end else if (w_timeout) begin
                  error_q <= 1'b1;
                  bidx_q  <= '0;
                  state_q <= ST_IDLE;
               end
            end
            ST_IN_BURST: begin
               if (w_burst_done) begin
                  if (bidx_q == '0) begin
                     if (w_cls == BC_S) begin
                        bidx_q   <= BIDX_W'(1);
                        shadow_q <= '0;
                        state_q  <= ST_WAIT_BURST;
                     end else begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     case (w_cls)
                        BC_A, BC_D: begin
                           shadow_q <= w_shadow_upd;
                           if (w_last) begin
                              command_q <= w_shadow_upd;
                              valid_q   <= 1'b1;
                              bidx_q    <= '0;
                              state_q   <= ST_IDLE;
                           end else begin
                              bidx_q  <= bidx_q + 1'b1;
                              state_q <= ST_WAIT_BURST;
                           end
                        end
                        BC_S: begin
                           bidx_q   <= BIDX_W'(1);
                           shadow_q <= '0;
                           state_q  <= ST_WAIT_BURST;
                        end
                        default: begin
                           error_q <= 1'b1;
                           bidx_q  <= '0;
                           state_q <= ST_IDLE;
                        end
                     endcase
                  end
                  // A pulse arriving while the old burst is judged already opens the next burst.
                  if (w_rise) begin
                     state_q <= ST_IN_BURST;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               bidx_q  <= '0;
            end
         endcase
      end
   end

   assign bus.COMMAND = command_q;
   assign bus.VALID   = valid_q;
   assign bus.ERROR   = error_q;
   assign bus.BUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_receiver.sv
// =====================================================================
// Module : tb_ir_receiver
// Brief  : Scoreboard bench for ir_receiver with a frame-level reference model
// Rev    : 1.0 - initial release
// =====================================================================
`default_nettype none

module tb_ir_receiver;

   localparam int CMD_LEN = 4;
   localparam int GAP     = 64;
   localparam int TOL     = 3;
   localparam int S_SZ    = 191;
   localparam int A_SZ    = 47;
   localparam int D_SZ    = 22;

   logic   CLK   = 1'b0;
   logic   RESET = 1'b1;
   longint cyc   = 0;

   ir_receiver_if #(.CMD_LEN(CMD_LEN)) bus ();

   ir_receiver #(
      .CMD_LEN       (CMD_LEN),
      .START_SIZE    (S_SZ),
      .ASSERT_SIZE   (A_SZ),
      .DEASSERT_SIZE (D_SZ),
      .TOL           (TOL),
      .GAP_CYCLES    (GAP)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      bit                 is_err;
      logic [CMD_LEN-1:0] cmd;
      longint             when;
   } exp_t;

   exp_t               exp_q[$];
   int                 vectors     = 0;
   int                 miscompares = 0;
   int                 m_bits[$];
   bit                 m_in_frame  = 1'b0;
   logic [CMD_LEN-1:0] m_cmd       = '0;
   longint             last_rise   = 0;
   int                 seq[$];
   bit                 busy_next   = 1'b0;

   task automatic chk(input string name, input longint act, input longint req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: 0=start, 1=one, 2=zero, 3=invalid, from the nominal sizes and tolerance.
   function automatic int cls_of(input int n);
      if (n >= S_SZ - TOL && n <= S_SZ + TOL) return 0;
      if (n >= A_SZ - TOL && n <= A_SZ + TOL) return 1;
      if (n >= D_SZ - TOL && n <= D_SZ + TOL) return 2;
      return 3;
   endfunction

   task automatic model_burst(input int n, input longint t);
      int   c;
      exp_t e;
      c      = cls_of(n);
      e.when = t + GAP + 4;
      e.cmd  = m_cmd;
      e.is_err = 1'b1;
      if (!m_in_frame) begin
         if (c == 0) begin
            m_in_frame = 1'b1;
            m_bits.delete();
         end else begin
            exp_q.push_back(e);
         end
      end else if (c == 0) begin
         m_bits.delete();
      end else if (c == 3) begin
         m_in_frame = 1'b0;
         exp_q.push_back(e);
      end else begin
         m_bits.push_back((c == 1) ? 1 : 0);
         if (m_bits.size() == CMD_LEN) begin
            for (int i = 0; i < CMD_LEN; i++) m_cmd[i] = (m_bits[i] != 0);
            m_in_frame = 1'b0;
            e.is_err   = 1'b0;
            e.cmd      = m_cmd;
            exp_q.push_back(e);
         end
      end
   endtask

   // Called and returns at 1 time unit after a rising CLK edge.
   task automatic send_burst(input int n);
      for (int i = 0; i < n; i++) begin
         bus.IR_IN = 1'b1;
         last_rise = cyc;
         repeat ($urandom_range(3, 2)) @(posedge CLK);
         #1 bus.IR_IN = 1'b0;
         repeat ($urandom_range(3, 2)) @(posedge CLK);
         #1;
      end
      model_burst(n, last_rise);
      repeat (GAP + $urandom_range(20, 2)) @(posedge CLK);
      #1;
   endtask

   task automatic send_seq();
      foreach (seq[i]) send_burst(seq[i]);
   endtask

   task automatic send_cmd(input logic [CMD_LEN-1:0] cmd);
      seq.delete();
      seq.push_back(S_SZ);
      for (int i = 0; i < CMD_LEN; i++) seq.push_back(cmd[i] ? A_SZ : D_SZ);
      send_seq();
   endtask

   task automatic line_idle();
      exp_t e;
      if (m_in_frame) begin
         m_in_frame = 1'b0;
         e.is_err   = 1'b1;
         e.cmd      = m_cmd;
         e.when     = last_rise + 4 * GAP + 4;
         exp_q.push_back(e);
      end
      repeat (4 * GAP + 20) @(posedge CLK);
      #1;
   endtask

   function automatic int rand_size(input int kind);
      case (kind)
         0:       return S_SZ - TOL + int'($urandom_range(2 * TOL));
         1:       return A_SZ - TOL + int'($urandom_range(2 * TOL));
         2:       return D_SZ - TOL + int'($urandom_range(2 * TOL));
         default: return int'($urandom_range(200, 1));
      endcase
   endfunction

   always @(negedge CLK) begin
      exp_t e;
      if (busy_next) begin
         chk("busy_after_event", longint'(bus.BUSY), 0);
         busy_next <= 1'b0;
      end
      if (!RESET && (bus.VALID || bus.ERROR)) begin
         chk("valid_error_exclusive", longint'(bus.VALID & bus.ERROR), 0);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: valid=%0b error=%0b command=%b, required no event (cycle %0d)",
                     bus.VALID, bus.ERROR, bus.COMMAND, cyc);
         end else begin
            e = exp_q.pop_front();
            chk(e.is_err ? "error_pulse" : "valid_pulse", longint'(bus.ERROR), longint'(e.is_err));
            chk("command", longint'(bus.COMMAND), longint'(e.cmd));
            chk("event_cycle", cyc, e.when);
            chk("busy_during_event", longint'(bus.BUSY), 1);
            busy_next <= 1'b1;
         end
      end
   end

   initial begin
      int r;
      bus.IR_IN = 1'b0;
      RESET     = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_command", longint'(bus.COMMAND), 0);
      chk("reset_valid", longint'(bus.VALID), 0);
      chk("reset_error", longint'(bus.ERROR), 0);
      chk("reset_busy", longint'(bus.BUSY), 0);
      @(posedge CLK);
      #1 RESET = 1'b0;

      // Decode one frame, then reset in the middle of the next.
      send_cmd(4'b0110);
      send_burst(S_SZ);
      for (int i = 0; i < 20; i++) begin
         bus.IR_IN = 1'b1;
         repeat (2) @(posedge CLK);
         #1 bus.IR_IN = 1'b0;
         repeat (2) @(posedge CLK);
         #1;
      end
      bus.IR_IN = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b1;
      bus.IR_IN  = 1'b0;
      m_in_frame = 1'b0;
      m_bits.delete();
      m_cmd = '0;
      repeat (2) @(negedge CLK);
      chk("midreset_command", longint'(bus.COMMAND), 0);
      chk("midreset_valid", longint'(bus.VALID), 0);
      chk("midreset_error", longint'(bus.ERROR), 0);
      chk("midreset_busy", longint'(bus.BUSY), 0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      send_cmd(4'b1010);

      // Command sweep with minimum inter-frame gaps.
      send_cmd(4'b0000);
      send_cmd(4'b0101);
      send_cmd(4'b1010);
      send_cmd(4'b1111);

      // Tolerance window edges.
      seq = '{188, 44, 25, 44, 25};
      send_seq();
      seq = '{194, 50, 19, 22, 47};
      send_seq();
      seq = '{191, 47, 22, 43};
      send_seq();
      line_idle();

      // Resynchronisation on a start burst mid-frame.
      seq = '{191, 47, 191, 22, 47, 22, 47};
      send_seq();

      // Truncated frame ends on the frame timeout.
      seq = '{191, 47, 22};
      send_seq();
      line_idle();

      // Randomised frames, including invalid and stray start bursts.
      for (int f = 0; f < 8; f++) begin
         seq.delete();
         seq.push_back(($urandom_range(9) == 0) ? rand_size(3) : rand_size(0));
         for (int b = 0; b < CMD_LEN; b++) begin
            r = int'($urandom_range(19));
            if (r == 0)      seq.push_back(rand_size(0));
            else if (r < 3)  seq.push_back(rand_size(3));
            else             seq.push_back(rand_size(1 + int'($urandom_range(1))));
         end
         send_seq();
         line_idle();
      end

      repeat (4 * GAP + 20) @(posedge CLK);
      @(negedge CLK);
      chk("pending_events", longint'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
